// File: rtl/sr_ou_sweep_scheduler.sv
// Sweep scheduler for a shared Ornstein-Uhlenbeck update engine.
// Owns the decimation counter and runs one req/ack sweep over all
// Schumann-resonance harmonics per decimation tick. It drives one-hot state
// and LFSR write enables and reports overrun and ack-timeout faults.
module sr_ou_sweep_scheduler #(
    parameter int NUM_HARMONICS = 5,
    parameter int IDX_W         = 3,
    parameter int DECIMATE_MAX  = 63,
    parameter int ACK_TIMEOUT   = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clk_en,
    input  logic                     freeze,
    input  logic                     clear_err,
    output logic                     eng_req,
    output logic [IDX_W-1:0]         eng_idx,
    input  logic                     eng_ack,
    output logic [NUM_HARMONICS-1:0] state_we,
    output logic [NUM_HARMONICS-1:0] lfsr_adv,
    output logic                     busy,
    output logic                     sweep_done,
    output logic                     overrun,
    output logic [7:0]               overrun_cnt,
    output logic                     timeout_err
);

    localparam int               DEC_W     = (DECIMATE_MAX > 0) ? $clog2(DECIMATE_MAX + 1) : 1;
    localparam logic [DEC_W-1:0] DEC_LAST  = DEC_W'(DECIMATE_MAX);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_HARMONICS - 1);
    localparam logic [7:0]       WAIT_LAST = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP, DONE} state_t;

    state_t                   state, state_nxt;
    logic [DEC_W-1:0]         decim_cnt;
    logic [IDX_W-1:0]         idx, idx_nxt;
    logic [7:0]               wait_cnt, wait_nxt;
    logic                     tick;
    logic                     ack_hit;
    logic                     timeout_hit;
    logic [NUM_HARMONICS-1:0] idx_onehot;

    assign tick = clk_en && (decim_cnt == '0);

    // Decimation counter: wraps DECIMATE_MAX -> 0 on each clk_en.
    always_ff @(posedge clk) begin
        if (rst)
            decim_cnt <= '0;
        else if (clk_en)
            decim_cnt <= (decim_cnt == DEC_LAST) ? '0 : decim_cnt + 1'b1;
    end

    // Sweep state, harmonic index and ack wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Next-state and output decode; a reset cycle forces every strobe low.
    // The last harmonic's trailing idle cycle is the DONE cycle itself, so
    // ISSUE goes straight to DONE there and sweep_done lands at tick+2N.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        wait_nxt    = '0;
        ack_hit     = 1'b0;
        timeout_hit = 1'b0;
        eng_req     = 1'b0;
        busy        = 1'b0;
        sweep_done  = 1'b0;
        overrun     = 1'b0;
        idx_onehot  = '0;
        unique case (state)
            IDLE: begin
                if (tick && !freeze) begin
                    state_nxt = ISSUE;
                    idx_nxt   = '0;
                end
            end
            ISSUE: begin
                eng_req = 1'b1;
                busy    = 1'b1;
                if (eng_ack) begin
                    ack_hit   = 1'b1;
                    state_nxt = (idx == IDX_LAST) ? DONE : GAP;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = (idx == IDX_LAST) ? DONE : GAP;
                end else begin
                    wait_nxt = wait_cnt + 8'd1;
                end
            end
            GAP: begin
                busy      = 1'b1;
                idx_nxt   = idx + 1'b1;
                state_nxt = ISSUE;
            end
            DONE: begin
                busy       = 1'b1;
                sweep_done = 1'b1;
                idx_nxt    = '0;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        overrun = tick && busy;
        for (int unsigned i = 0; i < NUM_HARMONICS; i++)
            idx_onehot[i] = (idx == IDX_W'(i));
        if (rst) begin
            eng_req     = 1'b0;
            busy        = 1'b0;
            sweep_done  = 1'b0;
            overrun     = 1'b0;
            ack_hit     = 1'b0;
            timeout_hit = 1'b0;
        end
    end

    assign eng_idx  = rst ? '0 : idx;
    assign state_we = ack_hit ? idx_onehot : '0;
    assign lfsr_adv = ack_hit ? idx_onehot : '0;

    // Fault reporting: a new event in the same cycle outranks clear_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_cnt <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (overrun)
                overrun_cnt <= clear_err ? 8'd1 :
                               ((overrun_cnt == 8'hFF) ? overrun_cnt : overrun_cnt + 8'd1);
            else if (clear_err)
                overrun_cnt <= '0;
            if (timeout_hit)
                timeout_err <= 1'b1;
            else if (clear_err)
                timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sr_ou_sweep_scheduler.sv
// Testbench for sr_ou_sweep_scheduler: a per-cycle reference model built on
// sweep/harmonic/request bookkeeping, plus directed literal timing checks.
module tb_sr_ou_sweep_scheduler;

    localparam int NH = 5;
    localparam int IW = 3;
    localparam int DM = 3;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clk_en = 1'b0;
    logic          freeze = 1'b0;
    logic          clear_err = 1'b0;
    logic          eng_ack = 1'b0;
    logic          eng_req;
    logic [IW-1:0] eng_idx;
    logic [NH-1:0] state_we;
    logic [NH-1:0] lfsr_adv;
    logic          busy;
    logic          sweep_done;
    logic          overrun;
    logic [7:0]    overrun_cnt;
    logic          timeout_err;

    sr_ou_sweep_scheduler #(
        .NUM_HARMONICS(NH),
        .IDX_W        (IW),
        .DECIMATE_MAX (DM),
        .ACK_TIMEOUT  (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .freeze     (freeze),
        .clear_err  (clear_err),
        .eng_req    (eng_req),
        .eng_idx    (eng_idx),
        .eng_ack    (eng_ack),
        .state_we   (state_we),
        .lfsr_adv   (lfsr_adv),
        .busy       (busy),
        .sweep_done (sweep_done),
        .overrun    (overrun),
        .overrun_cnt(overrun_cnt),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: sweep active, current harmonic, request vs. quiet cycle.
    int m_decim  = 0;
    int m_h      = 0;
    int m_w      = 0;
    int m_ovr    = 0;
    bit m_active = 0;
    bit m_quiet  = 0;
    bit m_terr   = 0;

    // Stimulus controls. ack_mode: 0 tied 1, 1 tied 0, 2 fixed delay, 3 random.
    bit s_rst = 1;
    bit s_en  = 0;
    bit s_frz = 0;
    bit s_clr = 0;
    bit rnd   = 0;
    int ack_mode  = 0;
    int ack_delay = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare every output to the model, advance the model.
    task automatic cycle();
        bit tick, e_req, e_busy, e_done, e_ovr, tmo;
        int exp_we;
        @(negedge clk);
        if (rnd) begin
            s_rst = ($urandom_range(0, 199) == 0);
            s_en  = 1'($urandom_range(0, 1));
            s_frz = ($urandom_range(0, 15) == 0);
            s_clr = ($urandom_range(0, 31) == 0);
        end
        rst       = s_rst;
        clk_en    = s_en;
        freeze    = s_frz;
        clear_err = s_clr;
        case (ack_mode)
            0:       eng_ack = 1'b1;
            1:       eng_ack = 1'b0;
            2:       eng_ack = m_active && !m_quiet && (m_w >= ack_delay);
            default: eng_ack = ($urandom_range(0, 3) == 0);
        endcase
        #1;
        tick   = clk_en && (m_decim == 0);
        e_req  = !rst && m_active && !m_quiet;
        e_busy = !rst && m_active;
        e_done = !rst && m_active && m_quiet && (m_h == NH - 1);
        e_ovr  = !rst && tick && m_active;
        exp_we = (e_req && eng_ack) ? (1 << m_h) : 0;

        chk("eng_req", eng_req, e_req);
        if (e_req) chk("eng_idx", eng_idx, m_h);
        chk("state_we", state_we, exp_we);
        chk("lfsr_adv", lfsr_adv, exp_we);
        chk("busy", busy, e_busy);
        chk("sweep_done", sweep_done, e_done);
        chk("overrun", overrun, e_ovr);
        chk("overrun_cnt", overrun_cnt, m_ovr);
        chk("timeout_err", timeout_err, m_terr);

        if (rst) begin
            m_decim = 0; m_active = 0; m_quiet = 0; m_h = 0; m_w = 0; m_ovr = 0; m_terr = 0;
        end else begin
            tmo = e_req && !eng_ack && (m_w == TO - 1);
            if (e_ovr) m_ovr = clear_err ? 1 : ((m_ovr < 255) ? m_ovr + 1 : 255);
            else if (clear_err) m_ovr = 0;
            if (tmo) m_terr = 1;
            else if (clear_err) m_terr = 0;
            if (!m_active) begin
                if (tick && !freeze) begin
                    m_active = 1; m_h = 0; m_quiet = 0; m_w = 0;
                end
            end else if (!m_quiet) begin
                if (eng_ack || tmo) m_quiet = 1;
                else m_w++;
            end else if (m_h == NH - 1) begin
                m_active = 0; m_h = 0;
            end else begin
                m_h++; m_quiet = 0; m_w = 0;
            end
            if (clk_en) m_decim = (m_decim == DM) ? 0 : m_decim + 1;
        end
        cyc++;
    endtask

    task automatic do_reset();
        rnd = 0; s_frz = 0; s_clr = 0; s_en = 0;
        s_rst = 1;
        cycle();
        cycle();
        s_rst = 0;
    endtask

    initial begin
        int we_cnt;
        int done_cnt;

        // Zero-wait ack: req on odd cycles with idx 0..4, done at +10, overruns at +4/+8.
        do_reset();
        chk("reset_busy", busy, 0);
        s_en = 1; ack_mode = 0;
        for (int k = 0; k <= 12; k++) begin
            cycle();
            chk("p1_req", eng_req, (k % 2 == 1) && (k <= 9));
            if ((k % 2 == 1) && (k <= 9)) chk("p1_idx", eng_idx, (k - 1) / 2);
            chk("p1_done", sweep_done, k == 10);
            chk("p1_ovr", overrun, (k == 4) || (k == 8));
        end
        for (int k = 0; k < 40; k++) cycle();

        // Ack delayed 3 cycles: each req lasts 4 cycles, one write per harmonic.
        do_reset();
        s_en = 1; ack_mode = 2; ack_delay = 3;
        we_cnt = 0;
        for (int k = 0; k <= 25; k++) begin
            cycle();
            if (state_we != '0) we_cnt++;
            chk("p2_req", eng_req, (k >= 1) && (k <= 24) && (k % 5 != 0));
            chk("p2_done", sweep_done, k == 25);
        end
        chk("p2_we_count", we_cnt, NH);
        for (int k = 0; k < 150; k++) cycle();

        // Ack never arrives: 15-cycle requests, no writes, sticky timeout.
        do_reset();
        s_en = 1; ack_mode = 1;
        for (int k = 0; k <= 16; k++) begin
            cycle();
            chk("p3_req", eng_req, (k >= 1) && (k <= 15));
            chk("p3_terr", timeout_err, k == 16);
        end
        done_cnt = 0;
        for (int k = 0; k < 200; k++) begin
            cycle();
            if (sweep_done) done_cnt++;
        end
        chk("p3_done_seen", done_cnt > 0, 1);

        // Ack delay 2 with a tick every 4 cycles: overrun count saturates, then clears.
        do_reset();
        s_en = 1; ack_mode = 2; ack_delay = 2;
        for (int k = 0; k < 1300; k++) cycle();
        chk("p4_sat", overrun_cnt, 255);
        s_en = 0; ack_mode = 0; s_clr = 1;
        cycle();
        s_clr = 0;
        cycle();
        chk("p4_clr_cnt", overrun_cnt, 0);
        chk("p4_clr_terr", timeout_err, 0);

        // Freeze: held at a tick -> idle; raised mid-sweep -> sweep completes; released -> sweeps.
        do_reset();
        s_en = 1; ack_mode = 0; s_frz = 1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("p5_frozen", busy, 0);
        end
        for (int k = 8; k <= 25; k++) begin
            s_frz = (k >= 10) && (k <= 21);
            cycle();
            chk("p5_req", eng_req, ((k >= 9) && (k <= 17) && (k % 2 == 1)) || (k == 25));
            chk("p5_done", sweep_done, k == 18);
        end
        s_frz = 0;

        // Reset during the idx 2 request aborts; the next sweep restarts at idx 0.
        do_reset();
        s_en = 1; ack_mode = 0;
        for (int k = 0; k < 5; k++) cycle();
        s_rst = 1;
        cycle();
        chk("p6_we_in_rst", state_we, 0);
        s_rst = 0;
        cycle();
        chk("p6_req", eng_req, 0);
        chk("p6_busy", busy, 0);
        chk("p6_we", state_we, 0);
        cycle();
        chk("p6_restart_req", eng_req, 1);
        chk("p6_restart_idx", eng_idx, 0);

        // Randomized traffic against the model.
        do_reset();
        ack_mode = 3; rnd = 1;
        for (int k = 0; k < 6000; k++) cycle();
        rnd = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
